alu_arbiter: RTL

Shares one ALU between `NREQ` requesters, for example the execute stage and a multicycle or debug unit, using per-requester valid/ready handshakes and round-robin arbitration. The block latches the granted operation, drives the ALU through a new `alu_if` modport `arb`, captures the result and flags into a response register, and returns them to the owning requester. It sits between the requesters and the single `alu` instance; the ALU itself stays purely combinational.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/alu_if.sv | 30 +++
 rtl/alu.sv | 44 ++++
 rtl/rr_grant.sv | 37 +++
 rtl/alu_arbiter.sv | 114 +++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU datapath types: word, ALU opcodes, ALU arbiter states.
// Revision : 1.0 - ALU arbiter state type and requester limit added
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Upper bound on requesters sharing one ALU through the arbiter.
    localparam int ALU_ARB_MAXREQ = 4;

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Brief    : Operand/result bundle between the single ALU and its driver.
// Revision : 1.0 - arb modport for the shared-ALU arbiter
// ============================================================================
interface alu_if;
    import cpu_types_pkg::*;

    aluop_t aluop;
    word_t  port_a;
    word_t  port_b;
    word_t  output_port;
    logic   zero;
    logic   negative;
    logic   overflow;

    // Driver side used by the arbiter.
    modport arb (
        output aluop, port_a, port_b,
        input  output_port, zero, negative, overflow
    );

    // The combinational ALU itself.
    modport alu (
        input  aluop, port_a, port_b,
        output output_port, zero, negative, overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Purely combinational 32-bit ALU with zero/negative/overflow flags.
// Revision : 1.0
// ============================================================================
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu aluif
);

    word_t w_result;
    logic  w_overflow;

    // Evaluate the selected operation and its signed-overflow condition.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (aluif.aluop)
            ALU_ADD: begin
                w_result   = aluif.port_a + aluif.port_b;
                w_overflow = (aluif.port_a[31] == aluif.port_b[31]) &&
                             (w_result[31] != aluif.port_a[31]);
            end
            ALU_SUB: begin
                w_result   = aluif.port_a - aluif.port_b;
                w_overflow = (aluif.port_a[31] != aluif.port_b[31]) &&
                             (w_result[31] != aluif.port_a[31]);
            end
            ALU_AND: w_result = aluif.port_a & aluif.port_b;
            ALU_OR:  w_result = aluif.port_a | aluif.port_b;
            ALU_XOR: w_result = aluif.port_a ^ aluif.port_b;
            default: w_result = '0;
        endcase
    end

    assign aluif.output_port = w_result;
    assign aluif.zero        = (w_result == '0);
    assign aluif.negative    = w_result[31];
    assign aluif.overflow    = w_overflow;

endmodule
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational round-robin picker: first valid index at or after
//            ptr, wrapping modulo N. Returns one-hot grant and its index.
// Revision : 1.0
// ============================================================================
module rr_grant #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    // Scan N candidates starting at ptr; the first valid one wins.
    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU among NREQ
//            requesters. Latches the granted op, evaluates it for one cycle,
//            registers result and flags, and holds them for the owner until
//            it takes the response.
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  aluop_t          req_aluop [NREQ],
    input  word_t           req_a     [NREQ],
    input  word_t           req_b     [NREQ],
    output logic [NREQ-1:0] resp_valid,
    input  logic [NREQ-1:0] resp_ready,
    output word_t           resp_data,
    output logic            resp_zero,
    output logic            resp_negative,
    output logic            resp_overflow,
    alu_if.arb              aluif
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    aluop_t          r_op;
    word_t           r_a;
    word_t           r_b;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_grant_idx;
    logic [PW-1:0]   w_ptr_next;

    rr_grant #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_grant (
        .valid     (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Rotation resumes just past the requester that was last served.
    assign w_ptr_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    // Only IDLE offers acceptance; the grant already implies req_valid.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    // Latched operands drive the ALU in every state so it stays quiet in IDLE.
    assign aluif.aluop  = r_op;
    assign aluif.port_a = r_a;
    assign aluif.port_b = r_b;

    // Arbiter FSM: accept in IDLE, evaluate in EXEC, hand back in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_op          <= ALU_ADD;
            r_a           <= '0;
            r_b           <= '0;
            resp_data     <= '0;
            resp_zero     <= 1'b0;
            resp_negative <= 1'b0;
            resp_overflow <= 1'b0;
            resp_valid    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_op    <= req_aluop[w_grant_idx];
                        r_a     <= req_a[w_grant_idx];
                        r_b     <= req_b[w_grant_idx];
                        r_owner <= w_grant_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data     <= aluif.output_port;
                    resp_zero     <= aluif.zero;
                    resp_negative <= aluif.negative;
                    resp_overflow <= aluif.overflow;
                    resp_valid    <= NREQ'(1) << r_owner;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (resp_ready[r_owner]) begin
                        resp_valid <= '0;
                        r_ptr      <= w_ptr_next;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
